// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and helpers for the LIF neuron
// Purpose: default neuron parameters, datapath widths and the 8-bit
//          saturating helper used by the membrane update.
// Ports:   none (package).
package lif_pkg;

  localparam int STATE_W        = 8;
  localparam int COUNT_W        = 7;

  localparam int THRESHOLD_DEF  = 200;
  localparam int LEAK_SHIFT_DEF = 1;
  localparam int REFRACTORY_DEF = 2;

  // Clamp a one-bit-wider sum to the membrane range instead of wrapping.
  function automatic logic [STATE_W-1:0] sat8(input logic [STATE_W:0] sum);
    return sum[STATE_W] ? {STATE_W{1'b1}} : sum[STATE_W-1:0];
  endfunction

endpackage

// File: rtl/lif_core.sv
// rtl/lif_core.sv - membrane integrator with leak, saturation, threshold and refractory
// Purpose: holds the membrane potential, applies leak and input current,
//          fires on threshold and holds the membrane at 0 while refractory.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous reset, active-high
//   en       in   update enable; 0 holds every register
//   current  in   8-bit unsigned input current
//   state    out  membrane potential register
//   spike    out  registered one-cycle spike pulse
//   fire     out  high when the coming enabled edge will emit a spike
module lif_core
  import lif_pkg::*;
#(
  parameter int THRESHOLD  = THRESHOLD_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int REFRACTORY = REFRACTORY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [STATE_W-1:0] current,
  output logic [STATE_W-1:0] state,
  output logic               spike,
  output logic               fire
);

  localparam int REFRAC_W = (REFRACTORY < 2) ? 1 : $clog2(REFRACTORY + 1);
  localparam logic [STATE_W-1:0]  THRESH      = STATE_W'(THRESHOLD);
  localparam logic [REFRAC_W-1:0] REFRAC_LOAD = REFRAC_W'(REFRACTORY);

  logic [REFRAC_W-1:0] refrac_cnt;
  logic                refractory;
  logic                at_threshold;
  logic [STATE_W-1:0]  integrated;

  assign refractory   = (refrac_cnt != '0);
  assign at_threshold = (state >= THRESH);

  // The spike counter in the top must advance on the same edge that sets
  // spike, so the firing decision is exported rather than the pulse.
  assign fire = en && !refractory && at_threshold;

  // Leak first, then add current; the sum is one bit wider so it can clamp.
  assign integrated = sat8({1'b0, current} + {1'b0, state >> LEAK_SHIFT});

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= '0;
      spike      <= 1'b0;
      refrac_cnt <= '0;
    end else if (en) begin
      if (refractory) begin
        state      <= '0;
        refrac_cnt <= refrac_cnt - REFRAC_W'(1);
        spike      <= 1'b0;
      end else if (at_threshold) begin
        state      <= '0;
        spike      <= 1'b1;
        refrac_cnt <= REFRAC_LOAD;
      end else begin
        state      <= integrated;
        spike      <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - LIF neuron user macro with tile pin mapping
// Purpose: wraps lif_core, keeps the 7-bit wrapping spike counter and maps
//          the neuron onto the standard user-project pins.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous reset, active-high
//   ena      in   design enable; 0 freezes all state
//   ui_in    in   input current, unsigned
//   uo_out   out  membrane potential
//   uio_in   in   unused
//   uio_out  out  {spike, spike_count[6:0]}
//   uio_oe   out  constant all-outputs
module lif_neuron
  import lif_pkg::*;
#(
  parameter int THRESHOLD  = THRESHOLD_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int REFRACTORY = REFRACTORY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [STATE_W-1:0] state;
  logic               spike;
  logic               fire;
  logic [COUNT_W-1:0] count;
  logic               unused_uio_in;

  lif_core #(
    .THRESHOLD (THRESHOLD),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRACTORY(REFRACTORY)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .current(ui_in),
    .state  (state),
    .spike  (spike),
    .fire   (fire)
  );

  // Wraps 127 -> 0 naturally through the 7-bit width.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
    end else if (fire) begin
      count <= count + COUNT_W'(1);
    end
  end

  assign unused_uio_in = &uio_in;

  assign uo_out  = state;
  assign uio_out = {spike, count};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - self-checking bench for lif_neuron
module tb_lif_neuron;

  localparam int THR   = 200;
  localparam int SHIFT = 1;
  localparam int REFR  = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  bit clk_run;
  int total;
  int bad;

  int m_state;
  int m_refrac;
  int m_spike;
  int m_count;

  typedef struct {
    bit         rst;
    bit         en;
    logic [7:0] ui;
    int         uo;
    int         spk;
    int         cnt;
  } vec_t;

  vec_t vt[$];

  lif_neuron dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial begin
    clk     = 1'b0;
    clk_run = 1'b1;
  end

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_refrac = 0;
    m_spike  = 0;
    m_count  = 0;
  endtask

  task automatic model_step(input bit e, input int u);
    if (!e) return;
    if (m_refrac > 0) begin
      m_state  = 0;
      m_refrac = m_refrac - 1;
      m_spike  = 0;
    end else if (m_state >= THR) begin
      m_state  = 0;
      m_spike  = 1;
      m_count  = (m_count + 1) % 128;
      m_refrac = REFR;
    end else begin
      m_state = u + m_state / (1 << SHIFT);
      if (m_state > 255) m_state = 255;
      m_spike = 0;
    end
  endtask

  task automatic step(input bit e, input logic [7:0] u);
    ena    = e;
    ui_in  = u;
    uio_in = 8'($urandom);
    @(posedge clk);
    model_step(e, int'(u));
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".uo"},    int'(uo_out),       m_state);
    check({tag, ".spike"}, int'(uio_out[7]),   m_spike);
    check({tag, ".count"}, int'(uio_out[6:0]), m_count);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    int spikes;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Asynchronous reset with the clock stopped.
    step(1'b1, 8'd150);
    check("pre_reset.uo", int'(uo_out), 150);
    ena     = 1'b0;
    clk_run = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check("async_rst.uo", int'(uo_out), 0);
    check("async_rst.uio_out", int'(uio_out), 0);
    check("async_rst.uio_oe", int'(uio_oe), 255);
    #40;
    check("rst_hold.uo", int'(uo_out), 0);
    check("rst_hold.uio_out", int'(uio_out), 0);
    check("rst_hold.uio_oe", int'(uio_oe), 255);
    rst_n = 1'b0;
    #3;
    check("release.uo", int'(uo_out), 0);
    clk_run = 1'b1;
    @(negedge clk);

    // Directed vectors: settle at 79, fire/refractory, saturation, enable hold.
    vt.push_back('{1'b1, 1'b1, 8'd40,  40,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  60,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  70,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  75,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  77,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  78,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  79,  0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd40,  79,  0, 0});
    vt.push_back('{1'b1, 1'b1, 8'd150, 150, 0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd150, 225, 0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd150, 0,   1, 1});
    vt.push_back('{1'b0, 1'b1, 8'd150, 0,   0, 1});
    vt.push_back('{1'b0, 1'b1, 8'd150, 0,   0, 1});
    vt.push_back('{1'b0, 1'b1, 8'd150, 150, 0, 1});
    vt.push_back('{1'b0, 1'b1, 8'd150, 225, 0, 1});
    vt.push_back('{1'b0, 1'b1, 8'd150, 0,   1, 2});
    vt.push_back('{1'b0, 1'b1, 8'd150, 0,   0, 2});
    vt.push_back('{1'b1, 1'b1, 8'd255, 255, 0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd255, 0,   1, 1});
    vt.push_back('{1'b1, 1'b1, 8'd150, 150, 0, 0});
    for (int k = 0; k < 5; k++) vt.push_back('{1'b0, 1'b0, 8'd150, 150, 0, 0});
    vt.push_back('{1'b0, 1'b1, 8'd150, 225, 0, 0});

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      step(vt[i].en, vt[i].ui);
      check($sformatf("vec%0d.uo", i),    int'(uo_out),       vt[i].uo);
      check($sformatf("vec%0d.spike", i), int'(uio_out[7]),   vt[i].spk);
      check($sformatf("vec%0d.count", i), int'(uio_out[6:0]), vt[i].cnt);
    end

    // 128 spikes wrap the counter back to 0.
    do_reset();
    spikes = 0;
    for (int c = 0; c < 700 && spikes < 128; c++) begin
      step(1'b1, 8'd255);
      if (m_spike != 0) spikes++;
      check_model("wrap");
    end
    check("wrap.spikes", spikes, 128);
    check("wrap.count_zero", int'(uio_out[6:0]), 0);
    check("wrap.spike_high", int'(uio_out[7]), 1);

    for (int c = 0; c < 8 && m_count != 1; c++) step(1'b1, 8'd255);
    check("after_wrap.count", int'(uio_out[6:0]), 1);
    step(1'b1, 8'd255);
    check("mid_refrac.uo", int'(uo_out), 0);
    check("mid_refrac.uio_out", int'(uio_out), 1);

    // Reset in the middle of the refractory period.
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check("refrac_rst.uo", int'(uo_out), 0);
    check("refrac_rst.uio_out", int'(uio_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b1, 8'd100);
    check("post_rst.uo", int'(uo_out), 100);
    check_model("post_rst");

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [7:0] u;
      bit         e;
      e = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       u = 8'($urandom_range(0, 50));
        1:       u = 8'($urandom_range(50, 150));
        2:       u = 8'($urandom_range(150, 255));
        default: u = 8'd255;
      endcase
      if ($urandom_range(0, 49) == 0) do_reset();
      step(e, u);
      check_model($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
